// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Build option: IMEM_ROUND_ROBIN_EN selects round-robin RUN arbitration.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH = 1024;
    localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH);

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic req_id_t;
    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_LOAD  = 1'b1;

    // Word address lies inside the memory
    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-port signal bundle for the instruction-memory arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface imem_arbiter_if
    import imem_pkg::*;
#(
    parameter int unsigned AW = IMEM_AW
) ();

    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [31:0]   fetch_rdata;
    logic          fetch_err;

    logic          ld_req;
    logic [31:0]   ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_gnt;
    logic          ld_err;
    logic          ld_done;
    logic          boot_busy;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        output ld_gnt, ld_err, boot_busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_req, ld_addr, ld_wdata, ld_done, mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
        input  ld_gnt, ld_err, boot_busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_prio_sel.sv
// Combinational two-requester select: loader-only in BOOT, priority or round-robin in RUN.
// IMEM_ROUND_ROBIN_EN swaps the starvation input for the last-granted pointer.
module imem_prio_sel
    import imem_pkg::*;
(
    input  logic    en,
    input  logic    run,
    input  logic    fetch_req,
    input  logic    ld_req,
`ifdef IMEM_ROUND_ROBIN_EN
    input  req_id_t rr_last,
`else
    input  logic    starve,
`endif
    output logic    fetch_gnt_c,
    output logic    ld_gnt_c
);

    logic fetch_first_c;

`ifdef IMEM_ROUND_ROBIN_EN
    assign fetch_first_c = (rr_last == REQ_LOAD);
`else
    assign fetch_first_c = starve;
`endif

    // At most one grant; contention resolved by fetch_first_c
    always_comb begin
        fetch_gnt_c = 1'b0;
        ld_gnt_c    = 1'b0;
        if (en) begin
            if (!run) begin
                ld_gnt_c = ld_req;
            end else if (fetch_req && ld_req) begin
                fetch_gnt_c = fetch_first_c;
                ld_gnt_c    = !fetch_first_c;
            end else begin
                fetch_gnt_c = fetch_req;
                ld_gnt_c    = ld_req;
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: boot-load phase, fetch/loader arbitration, range check, 1-cycle read return.
// Build option: IMEM_ROUND_ROBIN_EN selects round-robin RUN arbitration instead of loader priority.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH    = IMEM_DEPTH,
    parameter int unsigned AW       = IMEM_AW,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);

    state_t state_q;
    logic   rvalid_q;
    logic   ferr_q;
    logic   lderr_q;

    logic   fetch_gnt_c;
    logic   ld_gnt_c;
    logic   fetch_ok_c;
    logic   ld_ok_c;

    assign fetch_ok_c = in_range(bus.fetch_addr, DEPTH);
    assign ld_ok_c    = in_range(bus.ld_addr, DEPTH);

`ifdef IMEM_ROUND_ROBIN_EN
    req_id_t rr_q;

    imem_prio_sel u_prio_sel (
        .en          (!rst),
        .run         (state_q == RUN),
        .fetch_req   (bus.fetch_req),
        .ld_req      (bus.ld_req),
        .rr_last     (rr_q),
        .fetch_gnt_c (fetch_gnt_c),
        .ld_gnt_c    (ld_gnt_c)
    );

    // Last-granted requester drops to lowest priority
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= REQ_LOAD;
        end else if (fetch_gnt_c) begin
            rr_q <= REQ_FETCH;
        end else if (ld_gnt_c) begin
            rr_q <= REQ_LOAD;
        end
    end
`else
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt_q;

    imem_prio_sel u_prio_sel (
        .en          (!rst),
        .run         (state_q == RUN),
        .fetch_req   (bus.fetch_req),
        .ld_req      (bus.ld_req),
        .starve      (wait_cnt_q >= WW'(MAX_WAIT)),
        .fetch_gnt_c (fetch_gnt_c),
        .ld_gnt_c    (ld_gnt_c)
    );

    // Cycles fetch has been kept waiting, saturating at MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (bus.fetch_req && !fetch_gnt_c) begin
            if (wait_cnt_q < WW'(MAX_WAIT)) begin
                wait_cnt_q <= wait_cnt_q + WW'(1);
            end
        end else begin
            wait_cnt_q <= '0;
        end
    end
`endif

    // Boot/run FSM and one-cycle response pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            rvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            lderr_q  <= 1'b0;
        end else begin
            case (state_q)
                BOOT:    if (bus.ld_done) state_q <= RUN;
                RUN:     state_q <= RUN;
                default: state_q <= BOOT;
            endcase
            rvalid_q <= fetch_gnt_c;
            ferr_q   <= fetch_gnt_c && !fetch_ok_c;
            lderr_q  <= ld_gnt_c && !ld_ok_c;
        end
    end

    assign bus.fetch_gnt = fetch_gnt_c;
    assign bus.ld_gnt    = ld_gnt_c;
    assign bus.boot_busy = (state_q == BOOT);

    // Reset in flight drops any pending response immediately
    assign bus.fetch_rvalid = rvalid_q && !rst;
    assign bus.fetch_err    = rvalid_q && ferr_q && !rst;
    assign bus.fetch_rdata  = (rvalid_q && !ferr_q && !rst) ? bus.mem_rdata : NOP_INSTR;
    assign bus.ld_err       = lderr_q && !rst;

    // Out-of-range accesses are granted but never reach the memory
    assign bus.mem_en    = (fetch_gnt_c && fetch_ok_c) || (ld_gnt_c && ld_ok_c);
    assign bus.mem_we    = ld_gnt_c && ld_ok_c;
    assign bus.mem_addr  = ld_gnt_c    ? bus.ld_addr[AW-1:0] :
                           fetch_gnt_c ? bus.fetch_addr[AW-1:0] : '0;
    assign bus.mem_wdata = ld_gnt_c ? bus.ld_wdata : 32'h0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random traffic against a behavioural reference model.
module tb_imem_arbiter;

    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_arbiter_if bus ();

    imem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment memory, cleared while reset is held
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] shadow [DEPTH];
    bit          m_boot      = 1'b1;
    int          m_wait      = 0;
    bit          m_last_load = 1'b1;
    bit          p_rvalid    = 1'b0;
    bit          p_err       = 1'b0;
    bit          p_lderr     = 1'b0;
    logic [31:0] p_data      = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit fr, input logic [31:0] fa, input bit lr,
                        input logic [31:0] la, input logic [31:0] lw,
                        input bit ld, input bit r, output bit gf, output bit gl);
        bit f_ok, l_ok;
        logic [31:0] e_addr;
        @(negedge clk);
        rst            = r;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.ld_req     = lr;
        bus.ld_addr    = la;
        bus.ld_wdata   = lw;
        bus.ld_done    = ld;
        #1;
        f_ok = (fa < DEPTH);
        l_ok = (la < DEPTH);
        gf = 1'b0;
        gl = 1'b0;
        if (!r) begin
            if (m_boot) begin
                gl = lr;
            end else if (fr && lr) begin
`ifdef IMEM_ROUND_ROBIN_EN
                gf = m_last_load;
`else
                gf = (m_wait >= int'(MAX_WAIT));
`endif
                gl = !gf;
            end else begin
                gf = fr;
                gl = lr;
            end
        end
        e_addr = gl ? (la & 32'(DEPTH - 1)) : gf ? (fa & 32'(DEPTH - 1)) : 32'h0;
        chk("fetch_gnt",    32'(bus.fetch_gnt),    32'(gf));
        chk("ld_gnt",       32'(bus.ld_gnt),       32'(gl));
        chk("mem_en",       32'(bus.mem_en),       32'((gf && f_ok) || (gl && l_ok)));
        chk("mem_we",       32'(bus.mem_we),       32'(gl && l_ok));
        chk("mem_addr",     32'(bus.mem_addr),     e_addr);
        chk("mem_wdata",    bus.mem_wdata,         gl ? lw : 32'h0);
        chk("boot_busy",    32'(bus.boot_busy),    32'(m_boot));
        chk("fetch_rvalid", 32'(bus.fetch_rvalid), 32'(!r && p_rvalid));
        chk("fetch_err",    32'(bus.fetch_err),    32'(!r && p_rvalid && p_err));
        chk("fetch_rdata",  bus.fetch_rdata,       (!r && p_rvalid && !p_err) ? p_data : 32'h0);
        chk("ld_err",       32'(bus.ld_err),       32'(!r && p_lderr));
        if (r) begin
            m_boot = 1'b1; m_wait = 0; m_last_load = 1'b1;
            p_rvalid = 1'b0; p_err = 1'b0; p_lderr = 1'b0; p_data = 32'h0;
            for (int i = 0; i < int'(DEPTH); i++) shadow[i] = 32'h0;
        end else begin
            p_rvalid = gf;
            p_err    = gf && !f_ok;
            p_data   = (gf && f_ok) ? shadow[fa & 32'(DEPTH - 1)] : 32'h0;
            p_lderr  = gl && !l_ok;
            if (gl && l_ok) shadow[la & 32'(DEPTH - 1)] = lw;
`ifdef IMEM_ROUND_ROBIN_EN
            m_wait = 0;
`else
            if (fr && !gf) m_wait = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
            else           m_wait = 0;
`endif
            if (gf)      m_last_load = 1'b0;
            else if (gl) m_last_load = 1'b1;
            if (m_boot && ld) m_boot = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 19) == 0) return $urandom | 32'h0000_0400;
        return 32'($urandom_range(0, 15));
    endfunction

    initial begin
        bit gf, gl;
        bit cfr, clr;
        logic [31:0] cfa, cla, clw;
        int n_fg;

        bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0;
        bus.ld_req = 1'b0; bus.ld_addr = 32'h0; bus.ld_wdata = 32'h0; bus.ld_done = 1'b0;

        // Reset, fetch held off during BOOT, released after ld_done
        step(0, 0, 0, 0, 0, 0, 1, gf, gl);
        step(0, 0, 0, 0, 0, 0, 1, gf, gl);
        repeat (6) step(1, 32'd3, 0, 0, 0, 0, 0, gf, gl);
        step(1, 32'd3, 0, 0, 0, 1, 0, gf, gl);
        step(1, 32'd3, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 0, gf, gl);

        // Boot load two words, then back-to-back fetches
        step(0, 0, 0, 0, 0, 0, 1, gf, gl);
        step(0, 0, 1, 32'd0, 32'h8C0A0020, 0, 0, gf, gl);
        step(0, 0, 1, 32'd1, 32'h8C0A0021, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 1, 0, gf, gl);
        step(1, 32'd0, 0, 0, 0, 0, 0, gf, gl);
        step(1, 32'd1, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 0, gf, gl);

        // Continuous contention: starvation override (or alternation)
        n_fg = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 32'd1, 1, 32'd8 + 32'(k), 32'hA000_0000 + 32'(k), 0, 0, gf, gl);
            n_fg += int'(bus.fetch_gnt);
        end
`ifdef IMEM_ROUND_ROBIN_EN
        chk("contention_fetch_grants", 32'(n_fg), 32'd5);
`else
        chk("contention_fetch_grants", 32'(n_fg), 32'd2);
`endif
        step(0, 0, 0, 0, 0, 0, 0, gf, gl);

        // Out-of-range fetch and loader write, memory untouched
        step(1, 32'd1024, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 0, gf, gl);
        step(1, 32'd1023, 0, 0, 0, 0, 0, gf, gl);
        step(1, 32'd0, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 0, gf, gl);

        // Reset right after a fetch grant drops the response
        step(1, 32'd1, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 1, gf, gl);
        step(1, 32'd1, 0, 0, 0, 0, 0, gf, gl);

        // Write and ld_done in the same BOOT cycle
        step(0, 0, 0, 0, 0, 0, 1, gf, gl);
        step(0, 0, 1, 32'd2, 32'h1234_5678, 1, 0, gf, gl);
        step(1, 32'd2, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 0, 0, gf, gl);

        // Random traffic; requests held stable until the model says granted
        step(0, 0, 0, 0, 0, 0, 1, gf, gl);
        for (int k = 0; k < 8; k++) step(0, 0, 1, 32'(k), $urandom, 0, 0, gf, gl);
        step(0, 0, 0, 0, 0, 1, 0, gf, gl);
        cfr = 1'b0; clr = 1'b0; cfa = 32'h0; cla = 32'h0; clw = 32'h0;
        repeat (400) begin
            if (!cfr) begin cfr = ($urandom_range(0, 3) != 0); cfa = rand_addr(); end
            if (!clr) begin clr = ($urandom_range(0, 2) != 0); cla = rand_addr(); clw = $urandom; end
            step(cfr, cfa, clr, cla, clw, $urandom_range(0, 7) == 0, 0, gf, gl);
            if (gf) cfr = 1'b0;
            if (gl) clr = 1'b0;
        end
        step(0, 0, 0, 0, 0, 0, 0, gf, gl);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
